cr_gray_counter: RTL and testbench
==================================

CR_GRAY_COUNTER -- requirements
Module: cr_gray_counter

Interface
REQ-001 The block SHALL have parameter pWidth, default 4, meaning counter and datapath width in bits.
REQ-002 The block SHALL have parameter pInit, default 0, meaning the binary count value loaded on reset and on clear.
REQ-003 The block SHALL have port CLK, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, meaning reset, which is synchronous and active-high.
REQ-005 The block SHALL have port CLR, input, 1, meaning synchronous clear of the count to pInit.
REQ-006 The block SHALL have port LD, input, 1, meaning load the count from D.
REQ-007 The block SHALL have port D, input, pWidth, meaning the binary load value.
REQ-008 The block SHALL have port INC, input, 1, meaning increment the count by one.
REQ-009 The block SHALL have port DEC, input, 1, meaning decrement the count by one; it is present only when CR_GRAY_COUNTER_DEC_EN is defined.
REQ-010 The block SHALL have port B, output, pWidth, meaning the registered binary count.
REQ-011 The block SHALL have port G, output, pWidth, meaning the registered Gray code of the count.
REQ-012 The block SHALL have port WRAP, output, 1, meaning a registered one-cycle pulse on count wrap-around.

Function
REQ-013 Elaboration SHALL fail with a deliberately unresolvable module instance if pWidth < 2 or if pInit > 2^pWidth-1.
REQ-014 Update priority each edge SHALL be RST, then CLR, then LD, then INC/DEC, then hold.
REQ-015 All outputs SHALL be driven directly from flops with no combinational path from any input to B, G or WRAP.
REQ-016 Latency SHALL be one cycle: a command sampled at edge N is reflected on B, G and WRAP after edge N.
REQ-017 G SHALL always equal B ^ (B >> 1) and SHALL be computed from the next binary value so that G and B update on the same edge.
REQ-018 A single increment or decrement SHALL change exactly one bit of G, including across wrap.
REQ-019 Increment arithmetic SHALL be modulo 2^pWidth: from all-ones, the count goes to 0 and WRAP = 1 for one cycle.
REQ-020 WRAP SHALL be 0 on every cycle other than the one following a wrapping increment or decrement.
REQ-021 LD and CLR SHALL never assert WRAP, even if the loaded value differs from the current value by a wrap.
REQ-022 LD asserted together with INC (or DEC) SHALL load D unmodified; the count step is discarded.
REQ-023 INC low with no other command SHALL hold B and G, and WRAP SHALL go to 0.

Reset
REQ-024 On an edge with RST = 1, B SHALL become pInit, G SHALL become pInit ^ (pInit >> 1), and WRAP SHALL become 0, regardless of all other inputs.
REQ-025 RST asserted mid-count SHALL take effect at the next edge and discard any simultaneous LD, INC or DEC.
REQ-026 The first command SHALL be accepted on the first edge with RST = 0.

Configuration
REQ-027 With CR_GRAY_COUNTER_DEC_EN defined, the DEC port SHALL exist and decrement modulo 2^pWidth: from 0, the count goes to all-ones and WRAP = 1 for one cycle.
REQ-028 With CR_GRAY_COUNTER_DEC_EN defined, INC = DEC = 1 without LD SHALL hold the count and drive WRAP to 0.
REQ-029 Without CR_GRAY_COUNTER_DEC_EN, the DEC port SHALL be absent and the block SHALL be an up-counter only, with all other behaviour identical.

Verification
REQ-030 Scenario (pWidth=4, pInit=0): reset, then INC=1 for 16 cycles -> B goes 1..15 then 0; G goes 1,3,2,6,...,8,0; exactly one G bit changes per cycle; WRAP=1 only after the 16th edge.
REQ-031 Scenario: LD=1, D=4'hE, INC=1 in the same cycle -> B=4'hE, G=4'h9, WRAP=0; the next INC -> B=4'hF, G=4'h8.
REQ-032 Scenario: at B=4'h7, assert RST with LD=1, D=4'h3 and INC=1 -> B=pInit, G=pInit^(pInit>>1), WRAP=0; repeat with pInit=5 -> B=4'h5, G=4'h7.
REQ-033 Scenario: at B=4'h9, CLR=1 with LD=1 -> B=pInit; INC held low for 3 cycles -> B and G stable, WRAP=0.
REQ-034 Scenario (DEC_EN defined): at B=0, DEC=1 -> B=4'hF, G=4'h8, WRAP=1; then INC=DEC=1 -> B holds at 4'hF, WRAP=0.
REQ-035 Scenario: pWidth=1, or pWidth=4 with pInit=16 -> elaboration error.

Source files
------------

// File: rtl/cr_gray_counter.sv
// Binary/Gray up-counter with registered Gray output and wrap pulse.
// Define CR_GRAY_COUNTER_DEC_EN to add the DEC port (up/down counting).
module cr_gray_counter #(
    parameter int pWidth = 4,
    parameter int pInit  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              LD,
    input  logic [pWidth-1:0] D,
    input  logic              INC,
`ifdef CR_GRAY_COUNTER_DEC_EN
    input  logic              DEC,
`endif
    output logic [pWidth-1:0] B,
    output logic [pWidth-1:0] G,
    output logic              WRAP
);

    // Refuse to build with a degenerate width or an unrepresentable init.
    if (pWidth < 2 || pInit < 0 || pInit > (2 ** pWidth) - 1) begin : g_bad_param
        cr_gray_counter_invalid_parameters u_invalid ();
    end

    localparam logic [pWidth-1:0] INIT_B   = pWidth'(pInit);
    localparam logic [pWidth-1:0] ONE      = pWidth'(1);
    localparam logic [pWidth-1:0] ALL_ONES = '1;

    logic [pWidth-1:0] b_q;
    logic [pWidth-1:0] b_d;
    logic [pWidth-1:0] g_q;
    logic [pWidth-1:0] g_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              up;
    logic              down;

    // Decode the step direction; simultaneous up and down cancel out.
    always_comb begin
        up   = 1'b0;
        down = 1'b0;
`ifdef CR_GRAY_COUNTER_DEC_EN
        up   = INC & ~DEC;
        down = DEC & ~INC;
`else
        up   = INC;
`endif
    end

    // Next count by priority RST > CLR > LD > step > hold; Gray from next binary.
    always_comb begin
        b_d    = b_q;
        wrap_d = 1'b0;
        if (RST || CLR) begin
            b_d = INIT_B;
        end else if (LD) begin
            b_d = D;
        end else if (up) begin
            b_d    = b_q + ONE;
            wrap_d = (b_q == ALL_ONES);
        end else if (down) begin
            b_d    = b_q - ONE;
            wrap_d = (b_q == '0);
        end
        g_d = b_d ^ (b_d >> 1);
    end

    // State registers; all outputs come straight from these flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            b_q    <= INIT_B;
            g_q    <= INIT_B ^ (INIT_B >> 1);
            wrap_q <= 1'b0;
        end else begin
            b_q    <= b_d;
            g_q    <= g_d;
            wrap_q <= wrap_d;
        end
    end

    assign B    = b_q;
    assign G    = g_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_cr_gray_counter.sv
// Directed table-driven bench for cr_gray_counter (pInit=0 and pInit=5).
// Covers reset, priority, load, wrap and the optional decrement path.
module tb_cr_gray_counter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CLR = 1'b0;
    logic       LD  = 1'b0;
    logic [3:0] D   = 4'h0;
    logic       INC = 1'b0;
    logic       DEC = 1'b0;
    logic [3:0] b0, g0, b5, g5;
    logic       w0, w5;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cr_gray_counter #(.pWidth(4), .pInit(0)) dut0 (
        .CLK(CLK), .RST(RST), .CLR(CLR), .LD(LD), .D(D), .INC(INC),
`ifdef CR_GRAY_COUNTER_DEC_EN
        .DEC(DEC),
`endif
        .B(b0), .G(g0), .WRAP(w0)
    );

    cr_gray_counter #(.pWidth(4), .pInit(5)) dut5 (
        .CLK(CLK), .RST(RST), .CLR(CLR), .LD(LD), .D(D), .INC(INC),
`ifdef CR_GRAY_COUNTER_DEC_EN
        .DEC(DEC),
`endif
        .B(b5), .G(g5), .WRAP(w5)
    );

    typedef struct {
        logic       rst;
        logic       clr;
        logic       ld;
        logic       inc;
        logic [3:0] d;
        logic [3:0] eb;
        logic [3:0] eg;
        logic       ew;
        logic       chk5;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic ld,
                        input logic inc, input logic dec, input logic [3:0] d);
        RST = rst; CLR = clr; LD = ld; INC = inc; DEC = dec; D = d;
        @(posedge CLK);
        #1;
    endtask

    logic [3:0] prev_g;
    logic [3:0] eb;

    initial begin
        //            rst   clr   ld    inc   d     B     G     W     chk5
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'hE, 4'hE, 4'h9, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h8, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 4'h7, 4'h4, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 4'h9, 4'hD, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 4'h8, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].inc, 1'b0,
                 vecs[i].d);
            check($sformatf("vec%0d_B", i), b0, vecs[i].eb);
            check($sformatf("vec%0d_G", i), g0, vecs[i].eg);
            check($sformatf("vec%0d_WRAP", i), {3'b0, w0}, {3'b0, vecs[i].ew});
            if (vecs[i].chk5) begin
                check($sformatf("vec%0d_B5", i), b5, 4'h5);
                check($sformatf("vec%0d_G5", i), g5, 4'h7);
                check($sformatf("vec%0d_WRAP5", i), {3'b0, w5}, 4'h0);
            end
        end

        // Full 16-step sweep from reset: Gray sequence and single wrap.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        check("sweep_reset_B", b0, 4'h0);
        prev_g = g0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
            eb = 4'((i + 1) % 16);
            check($sformatf("sweep%0d_B", i), b0, eb);
            check($sformatf("sweep%0d_G", i), g0, eb ^ (eb >> 1));
            check($sformatf("sweep%0d_WRAP", i), {3'b0, w0},
                  (i == 15) ? 4'h1 : 4'h0);
            check($sformatf("sweep%0d_onebit", i),
                  4'($countones(g0 ^ prev_g)), 4'h1);
            prev_g = g0;
        end

        // Reset from mid-count (B=7) with competing LD/INC.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7);
        check("mid_ld_B", b0, 4'h7);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h3);
        check("mid_rst_B", b0, 4'h0);
        check("mid_rst_G5", g5, 4'h7);
        // First command accepted right after reset.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        check("post_rst_B", b0, 4'h1);
        check("post_rst_B5", b5, 4'h6);
        check("post_rst_G5", g5, 4'h5);

`ifdef CR_GRAY_COUNTER_DEC_EN
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("dec_wrap_B", b0, 4'hF);
        check("dec_wrap_G", g0, 4'h8);
        check("dec_wrap_WRAP", {3'b0, w0}, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
        check("incdec_B", b0, 4'hF);
        check("incdec_WRAP", {3'b0, w0}, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        check("dec_B", b0, 4'hE);
        check("dec_G", g0, 4'h9);
`endif

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
